clmul_iter_unit: RTL and testbench



---
 rtl/clmul_iter_unit_pkg.sv | 21 ++
 rtl/clmul_iter_unit_step.sv | 48 ++++
 rtl/clmul_iter_unit.sv | 167 ++++++++++++++++
 tb/tb_clmul_iter_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/clmul_iter_unit_pkg.sv
// -----------------------------------------------------------------------------
// clmul_iter_unit_pkg
// Shared types for the iterative carry-less multiply unit:
//   clmul_op_e    - operation select (CLMUL / CLMULH / CLMULR, 2'd3 reserved)
//   clmul_state_e - control FSM states of the unit
// -----------------------------------------------------------------------------
package clmul_iter_unit_pkg;

  typedef enum logic [1:0] {
    CLMUL  = 2'd0,
    CLMULH = 2'd1,
    CLMULR = 2'd2
  } clmul_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } clmul_state_e;

endpackage

// File: rtl/clmul_iter_unit_step.sv
// -----------------------------------------------------------------------------
// clmul_step
// Purely combinational carry-less multiply step. For each bit i of the current
// chunk of operand B, XORs (a << (k+i)) into the accumulator.
// Ports:
//   a_i       XLEN             operand A
//   b_chunk_i BITS_PER_CYCLE   current chunk of operand B (LSB = bit k)
//   k_i       clog2(XLEN)      shift base of this chunk
//   acc_i     2*XLEN           accumulator in
//   acc_o     2*XLEN           accumulator out
// -----------------------------------------------------------------------------
module clmul_step
  import clmul_iter_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 4
) (
  input  logic [XLEN-1:0]           a_i,
  input  logic [BITS_PER_CYCLE-1:0] b_chunk_i,
  input  logic [$clog2(XLEN)-1:0]   k_i,
  input  logic [2*XLEN-1:0]         acc_i,
  output logic [2*XLEN-1:0]         acc_o
);

  localparam int KW = $clog2(XLEN);

  logic [2*XLEN-1:0] a_ext;
  logic [2*XLEN-1:0] term [BITS_PER_CYCLE];

  assign a_ext = {{XLEN{1'b0}}, a_i};

  generate
    for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_term
      // One extra bit keeps k+i from wrapping for any legal parameter set.
      logic [KW:0] sh;
      assign sh         = {1'b0, k_i} + (KW+1)'(gi);
      assign term[gi]   = b_chunk_i[gi] ? (a_ext << sh) : '0;
    end
  endgenerate

  always_comb begin
    acc_o = acc_i;
    for (int i = 0; i < BITS_PER_CYCLE; i++) begin
      acc_o = acc_o ^ term[i];
    end
  end

endmodule

// File: rtl/clmul_iter_unit.sv
// -----------------------------------------------------------------------------
// clmul_iter_unit
// Iterative carry-less multiplier (CLMUL / CLMULH / CLMULR). Consumes
// BITS_PER_CYCLE bits of B per cycle and finishes early once the remaining
// B bits are all zero. Single operation in flight, valid/ready on both sides.
// Ports:
//   clk_i, rst_i (async, active-high), flush_i
//   valid_i / ready_o, op_i, operand_a_i, operand_b_i, trans_id_i  - request
//   valid_o / ready_i, result_o, trans_id_o                        - response
// All outputs are registered.
// -----------------------------------------------------------------------------
module clmul_iter_unit
  import clmul_iter_unit_pkg::*;
#(
  parameter int XLEN           = 64,
  parameter int BITS_PER_CYCLE = 4,
  parameter int TRANS_ID_BITS  = 3
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     valid_i,
  output logic                     ready_o,
  input  logic [1:0]               op_i,
  input  logic [XLEN-1:0]          operand_a_i,
  input  logic [XLEN-1:0]          operand_b_i,
  input  logic [TRANS_ID_BITS-1:0] trans_id_i,
  output logic                     valid_o,
  input  logic                     ready_i,
  output logic [XLEN-1:0]          result_o,
  output logic [TRANS_ID_BITS-1:0] trans_id_o
);

  localparam int ITER = XLEN / BITS_PER_CYCLE;
  localparam int KW   = $clog2(XLEN);
  localparam int CW   = $clog2(ITER);

  generate
    if (!(XLEN == 32 || XLEN == 64)) begin : g_bad_xlen
      $error("clmul_iter_unit: XLEN must be 32 or 64");
    end
    if (!(BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 ||
          BITS_PER_CYCLE == 4 || BITS_PER_CYCLE == 8) ||
        (XLEN % BITS_PER_CYCLE) != 0) begin : g_bad_bpc
      $error("clmul_iter_unit: BITS_PER_CYCLE must be 1,2,4,8 and divide XLEN");
    end
  endgenerate

  clmul_state_e             state_q;
  logic [2*XLEN-1:0]        acc_q;
  logic [XLEN-1:0]          a_q;
  logic [XLEN-1:0]          b_q;
  logic [1:0]               op_q;
  logic [TRANS_ID_BITS-1:0] id_q;
  logic [CW-1:0]            cnt_q;
  logic                     ready_q;
  logic                     valid_q;
  logic [XLEN-1:0]          result_q;
  logic [TRANS_ID_BITS-1:0] trans_id_q;

  logic [2*XLEN-1:0]        acc_d;
  logic [XLEN-1:0]          b_d;
  logic [XLEN-1:0]          result_d;
  logic [KW-1:0]            k_base;
  logic                     last_iter;

  // Chunk shift base k = cnt * BITS_PER_CYCLE (power of two, so a shift).
  assign k_base = KW'(cnt_q) << $clog2(BITS_PER_CYCLE);

  clmul_step #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BITS_PER_CYCLE)
  ) u_step (
    .a_i       (a_q),
    .b_chunk_i (b_q[BITS_PER_CYCLE-1:0]),
    .k_i       (k_base),
    .acc_i     (acc_q),
    .acc_o     (acc_d)
  );

  assign b_d       = b_q >> BITS_PER_CYCLE;
  assign last_iter = (b_d == '0) || (cnt_q == CW'(ITER - 1));

  // Result is taken from the accumulator value produced in the final step.
  // The reserved encoding falls through to the low half (CLMUL).
  always_comb begin
    result_d = acc_d[XLEN-1:0];
    case (op_q)
      CLMULH:  result_d = acc_d[2*XLEN-1:XLEN];
      CLMULR:  result_d = acc_d[2*XLEN-2:XLEN-1];
      default: result_d = acc_d[XLEN-1:0];
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= ST_IDLE;
      acc_q      <= '0;
      a_q        <= '0;
      b_q        <= '0;
      op_q       <= '0;
      id_q       <= '0;
      cnt_q      <= '0;
      ready_q    <= 1'b1;
      valid_q    <= 1'b0;
      result_q   <= '0;
      trans_id_q <= '0;
    end else if (flush_i) begin
      // Flush wins over accept and completion; any pending result is dropped.
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (valid_i && ready_q) begin
            a_q   <= operand_a_i;
            b_q   <= operand_b_i;
            op_q  <= op_i;
            id_q  <= trans_id_i;
            acc_q <= '0;
            cnt_q <= '0;
            ready_q <= 1'b0;
            if (operand_b_i == '0) begin
              state_q    <= ST_DONE;
              valid_q    <= 1'b1;
              result_q   <= '0;
              trans_id_q <= trans_id_i;
            end else begin
              state_q <= ST_BUSY;
            end
          end
        end
        ST_BUSY: begin
          acc_q <= acc_d;
          b_q   <= b_d;
          cnt_q <= cnt_q + CW'(1);
          if (last_iter) begin
            state_q    <= ST_DONE;
            valid_q    <= 1'b1;
            result_q   <= result_d;
            trans_id_q <= id_q;
          end
        end
        ST_DONE: begin
          // ready_o stays low on the handshake cycle, so no same-cycle accept.
          if (ready_i) begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
            ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          valid_q <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o    = ready_q;
  assign valid_o    = valid_q;
  assign result_o   = result_q;
  assign trans_id_o = trans_id_q;

endmodule

// File: tb/tb_clmul_iter_unit.sv
// -----------------------------------------------------------------------------
// tb_clmul_iter_unit
// Self-checking bench for clmul_iter_unit (XLEN=64, BITS_PER_CYCLE=4):
// directed vector table, backpressure / flush / async-reset sequences, and a
// randomized sweep against a bit-serial carry-less multiply reference.
// -----------------------------------------------------------------------------
module tb_clmul_iter_unit;
  import clmul_iter_unit_pkg::*;

  localparam int XLEN = 64;
  localparam int BPC  = 4;
  localparam int TIDW = 3;
  localparam int N_RANDOM = 1500;

  logic            clk = 1'b0;
  logic            rst_i = 1'b1;
  logic            flush_i = 1'b0;
  logic            valid_i = 1'b0;
  logic            ready_o;
  logic [1:0]      op_i = 2'd0;
  logic [XLEN-1:0] operand_a_i = '0;
  logic [XLEN-1:0] operand_b_i = '0;
  logic [TIDW-1:0] trans_id_i = '0;
  logic            valid_o;
  logic            ready_i = 1'b1;
  logic [XLEN-1:0] result_o;
  logic [TIDW-1:0] trans_id_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  clmul_iter_unit #(
    .XLEN           (XLEN),
    .BITS_PER_CYCLE (BPC),
    .TRANS_ID_BITS  (TIDW)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst_i),
    .flush_i     (flush_i),
    .valid_i     (valid_i),
    .ready_o     (ready_o),
    .op_i        (op_i),
    .operand_a_i (operand_a_i),
    .operand_b_i (operand_b_i),
    .trans_id_i  (trans_id_i),
    .valid_o     (valid_o),
    .ready_i     (ready_i),
    .result_o    (result_o),
    .trans_id_o  (trans_id_o)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference: textbook carry-less product, bit by bit over B.
  function automatic logic [63:0] ref_clmul(input logic [1:0] op, input logic [63:0] a,
                                            input logic [63:0] b);
    logic [127:0] p;
    p = '0;
    for (int i = 0; i < 64; i++) begin
      if (b[i]) p = p ^ ({64'b0, a} << i);
    end
    case (op)
      2'd1:    return p[127:64];
      2'd2:    return p[126:63];
      default: return p[63:0];
    endcase
  endfunction

  function automatic int ref_lat(input logic [63:0] b);
    int h;
    if (b == 0) return 1;
    h = 0;
    for (int i = 0; i < 64; i++) if (b[i]) h = i;
    return h / BPC + 2;
  endfunction

  task automatic issue(input logic [1:0] op, input logic [63:0] a, input logic [63:0] b,
                       input logic [TIDW-1:0] id);
    int guard;
    guard = 0;
    while (!ready_o && guard < 50) begin
      @(posedge clk); #1;
      guard++;
    end
    if (!ready_o) check("issue_ready_timeout", 64'(ready_o), 64'd1);
    op_i = op; operand_a_i = a; operand_b_i = b; trans_id_i = id;
    valid_i = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
  endtask

  // Latency counts from the accept edge: 1 means valid right after that edge.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!valid_o) check("valid_timeout", 64'(valid_o), 64'd1);
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [TIDW-1:0] id, input int stall);
    int lat;
    logic [63:0] exp_res;
    logic [63:0] r0;
    exp_res = ref_clmul(op, a, b);
    if (stall > 0) ready_i = 1'b0;
    issue(op, a, b, id);
    wait_valid(lat);
    r0 = result_o;
    check({name, "_result"}, result_o, exp_res);
    check({name, "_id"}, 64'(trans_id_o), 64'(id));
    check({name, "_lat"}, 64'(lat), 64'(ref_lat(b)));
    if (stall > 0) begin
      repeat (stall) begin @(posedge clk); #1; end
      check({name, "_stall_hold"}, {62'd0, valid_o, ready_o}, 64'd2);
      check({name, "_stall_res"}, result_o, r0);
    end
    $display("%s op=%0d a=%h b=%h id=%0d res=%h lat=%0d", name, op, a, b, id, r0, lat);
    ready_i = 1'b1;
    @(posedge clk); #1;
  endtask

  typedef struct {
    logic [1:0]      op;
    logic [63:0]     a;
    logic [63:0]     b;
    logic [TIDW-1:0] id;
    logic [63:0]     exp_res;
    int              exp_lat;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int lat;
    logic [63:0] r_hold;
    logic [TIDW-1:0] id_hold;
    logic seen;

    vecs[0] = '{2'd0, 64'h3, 64'h3, 3'd1, 64'h5, 2};
    vecs[1] = '{2'd1, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd2,
                64'h4000_0000_0000_0000, 17};
    vecs[2] = '{2'd2, 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 3'd3,
                64'h8000_0000_0000_0000, 17};
    vecs[3] = '{2'd0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 3'd7, 64'h0, 1};
    vecs[4] = '{2'd0, 64'h5, 64'h5, 3'd4, 64'h11, 2};
    vecs[5] = '{2'd3, 64'h3, 64'h3, 3'd5, 64'h5, 2};
    vecs[6] = '{2'd0, 64'h1, 64'h10, 3'd6, 64'h10, 3};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_valid", 64'(valid_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    check("rst_id", 64'(trans_id_o), 64'd0);
    @(negedge clk); rst_i = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int v = 0; v < 7; v++) begin
      issue(vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].id);
      wait_valid(lat);
      check($sformatf("vec%0d_result", v), result_o, vecs[v].exp_res);
      check($sformatf("vec%0d_id", v), 64'(trans_id_o), 64'(vecs[v].id));
      check($sformatf("vec%0d_lat", v), 64'(lat), 64'(vecs[v].exp_lat));
      $display("vec%0d op=%0d a=%h b=%h res=%h lat=%0d", v, vecs[v].op, vecs[v].a,
               vecs[v].b, result_o, lat);
      @(posedge clk); #1;
      check($sformatf("vec%0d_ready_after", v), 64'(ready_o), 64'd1);
    end

    // Backpressure: result held, new requests ignored while DONE
    ready_i = 1'b0;
    issue(2'd0, 64'h3, 64'h3, 3'd6);
    wait_valid(lat);
    r_hold = result_o;
    id_hold = trans_id_o;
    check("bp_result", r_hold, 64'h5);
    for (int c = 0; c < 5; c++) begin
      valid_i = 1'b1; trans_id_i = 3'd1; operand_a_i = 64'h7; operand_b_i = 64'h9;
      @(posedge clk); #1;
      check($sformatf("bp%0d_valid_ready", c), {62'd0, valid_o, ready_o}, 64'd2);
      check($sformatf("bp%0d_result", c), result_o, r_hold);
      check($sformatf("bp%0d_id", c), 64'(trans_id_o), 64'(id_hold));
    end
    valid_i = 1'b0;
    ready_i = 1'b1;
    @(posedge clk); #1;
    check("bp_release", {62'd0, valid_o, ready_o}, 64'd1);
    $display("backpressure res=%h id=%0d", r_hold, id_hold);

    // Flush on the third BUSY cycle of a full-length op
    issue(2'd1, 64'hDEAD_BEEF_0123_4567, 64'h8000_0000_0000_0001, 3'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
    check("flush_ready", {62'd0, valid_o, ready_o}, 64'd1);
    seen = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    check("flush_no_valid", 64'(seen), 64'd0);
    $display("flush done");
    run_op("post_flush", 2'd0, 64'h5, 64'h5, 3'd5, 0);

    // Asynchronous reset in the middle of BUSY
    issue(2'd0, 64'h1234_5678_9ABC_DEF0, 64'h8000_0000_0000_0000, 3'd3);
    @(posedge clk); #1;
    @(posedge clk); #3;
    rst_i = 1'b1;
    #1;
    check("arst_outputs", {60'd0, ready_o, valid_o, (result_o == 64'd0), (trans_id_o == '0)},
          64'hB);
    @(negedge clk); rst_i = 1'b0;
    @(posedge clk); #1;
    $display("async reset done");

    // Randomized sweep against the reference model
    for (int n = 0; n < N_RANDOM; n++) begin
      logic [1:0]  op;
      logic [63:0] a;
      logic [63:0] b;
      op = 2'($urandom_range(0, 3));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom} >> $urandom_range(0, 63);
      if ($urandom_range(0, 15) == 0) b = 64'd0;
      run_op($sformatf("rnd%0d", n), op, a, b, 3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
